// File: rtl/lfsr_pkg.sv
// Shared types and known-maximal tap constants for the LFSR generators.
package lfsr_pkg;

  typedef enum logic {LFSR_FIB, LFSR_GAL} lfsr_mode_e;

  localparam logic [7:0]  LFSR8_MAX_TAPS  = 8'hB8;
  localparam logic [15:0] LFSR16_MAX_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR next-state function, Fibonacci or Galois form.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   TAPS  = 8'hB8,
  parameter lfsr_mode_e         MODE  = LFSR_FIB
) (
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt
);

  generate
    if (MODE == LFSR_FIB) begin : g_fib
      // Feedback is the parity of the tapped bits, shifted in at the LSB.
      assign nxt = {q[WIDTH-2:0], ^(q & TAPS)};
    end else begin : g_gal
      assign nxt = (q >> 1) ^ (q[0] ? TAPS : {WIDTH{1'b0}});
    end
  endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// LFSR generator with seed capture, step enable and period measurement.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter lfsr_mode_e       MODE  = LFSR_FIB
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             no_repeat,
  output logic             zero_seed
);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] start_p0;
  logic [WIDTH-1:0] cnt_p0;

  // An all-zero seed would lock most tap sets at zero, so it becomes 1.
  function automatic logic [WIDTH-1:0] sanitise(input logic [WIDTH-1:0] s);
    return (s == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : s;
  endfunction

  lfsr_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .MODE  (MODE)
  ) u_next (
    .q   (q),
    .nxt (nxt)
  );

  // Stage p0: state, start reference, step counter and sticky flags.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      q            <= sanitise(seed);
      start_p0     <= sanitise(seed);
      cnt_p0       <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      no_repeat    <= 1'b0;
      zero_seed    <= (seed == '0);
    end else if (en) begin
      q <= nxt;
      if (cnt_p0 != '1)
        cnt_p0 <= cnt_p0 + 1'b1;
      if (nxt == start_p0 && !period_valid && !no_repeat) begin
        period       <= cnt_p0 + 1'b1;
        period_valid <= 1'b1;
      end else if (cnt_p0 == '1 && !period_valid) begin
        // 2^WIDTH steps without return: the start state is off any cycle.
        no_repeat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: 8-bit Fibonacci, 8-bit Galois and 4-bit degenerate taps.
module tb_lfsr_gen;
  import lfsr_pkg::*;

  logic       clk = 1'b0;
  logic       reset, load, en;
  logic [7:0] seed8;
  logic [3:0] seed4;

  logic [7:0] q_f, per_f, q_g, per_g;
  logic       pv_f, nr_f, zs_f, pv_g, nr_g, zs_g;
  logic [3:0] q_w, per_w;
  logic       pv_w, nr_w, zs_w;

  int nchk  = 0;
  int nfail = 0;

  typedef struct {
    logic [7:0] f;
    logic [7:0] g;
    logic [3:0] w;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mf, mg;
  logic [3:0] mw;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .MODE(LFSR_FIB)) dut_f (
    .clk(clk), .reset(reset), .seed(seed8), .load(load), .en(en),
    .q(q_f), .period(per_f), .period_valid(pv_f), .no_repeat(nr_f), .zero_seed(zs_f));

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .MODE(LFSR_GAL)) dut_g (
    .clk(clk), .reset(reset), .seed(seed8), .load(load), .en(en),
    .q(q_g), .period(per_g), .period_valid(pv_g), .no_repeat(nr_g), .zero_seed(zs_g));

  lfsr_gen #(.WIDTH(4), .TAPS(4'b0011), .MODE(LFSR_FIB)) dut_w (
    .clk(clk), .reset(reset), .seed(seed4), .load(load), .en(en),
    .q(q_w), .period(per_w), .period_valid(pv_w), .no_repeat(nr_w), .zero_seed(zs_w));

  function automatic logic [7:0] fib8(input logic [7:0] s);
    logic fb = 1'b0;
    for (int i = 0; i < 8; i++) if (i == 7 || i == 5 || i == 4 || i == 3) fb ^= s[i];
    return {s[6:0], fb};
  endfunction

  function automatic logic [7:0] gal8(input logic [7:0] s);
    logic [7:0] t = 8'hB8;
    logic [7:0] n;
    for (int i = 0; i < 7; i++) n[i] = s[i+1] ^ (s[0] & t[i]);
    n[7] = s[0] & t[7];
    return n;
  endfunction

  function automatic logic [3:0] fib4(input logic [3:0] s);
    return {s[2:0], s[0] ^ s[1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, push the model's expected state, then pop and compare after the edge.
  task automatic cycle(input logic r, input logic ld, input logic e, input logic [7:0] s);
    exp_t x;
    reset = r; load = ld; en = e; seed8 = s;
    if (r || ld) begin
      mf = (s == 8'h00) ? 8'h01 : s;
      mg = mf;
      mw = (seed4 == 4'h0) ? 4'h1 : seed4;
    end else if (e) begin
      mf = fib8(mf);
      mg = gal8(mg);
      mw = fib4(mw);
    end
    x.f = mf; x.g = mg; x.w = mw;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("q_fib", 32'(q_f), 32'(x.f));
    chk("q_gal", 32'(q_g), 32'(x.g));
    chk("q_w4", 32'(q_w), 32'(x.w));
  endtask

  initial begin
    int n, iter;
    logic e;
    reset = 1'b1; load = 1'b0; en = 1'b0; seed8 = 8'h32; seed4 = 4'h8;
    mf = '0; mg = '0; mw = '0;

    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'h32);
    chk("rst_q_fib", 32'(q_f), 32'h32);
    chk("rst_pv", 32'(pv_f), 0);
    chk("rst_nr", 32'(nr_f), 0);
    chk("rst_zs", 32'(zs_f), 0);
    chk("rst_q_w4", 32'(q_w), 32'h8);

    cycle(1'b0, 1'b0, 1'b1, 8'h32);
    chk("first_fib", 32'(q_f), 32'h64);
    chk("first_gal", 32'(q_g), 32'h19);
    chk("first_w4", 32'(q_w), 32'h0);
    for (int i = 2; i <= 255; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h32);
      if (i == 15) chk("w4_nr_at15", 32'(nr_w), 0);
      if (i == 16) begin
        chk("w4_nr_at16", 32'(nr_w), 1);
        chk("w4_pv_at16", 32'(pv_w), 0);
      end
      if (i == 254) chk("fib_pv_at254", 32'(pv_f), 0);
    end
    chk("fib_pv", 32'(pv_f), 1);
    chk("fib_period", 32'(per_f), 255);
    chk("fib_q_back", 32'(q_f), 32'h32);
    chk("fib_nr", 32'(nr_f), 0);
    chk("gal_pv", 32'(pv_g), 1);
    chk("gal_period", 32'(per_g), 255);
    chk("gal_q_back", 32'(q_g), 32'h32);
    chk("w4_q_zero", 32'(q_w), 0);
    chk("w4_pv_end", 32'(pv_w), 0);

    // Keep running past the measurement: period stays frozen.
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0, 1'b1, 8'h32);
    chk("fib_period_frozen", 32'(per_f), 255);
    chk("fib_pv_sticky", 32'(pv_f), 1);

    // Load with en high at step 100 restarts the measurement.
    cycle(1'b0, 1'b1, 1'b1, 8'hA5);
    chk("load_q", 32'(q_f), 32'hA5);
    chk("load_pv", 32'(pv_f), 0);
    chk("load_period", 32'(per_f), 0);
    for (int i = 1; i <= 255; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'hA5);
      if (i == 254) chk("load_pv_at254", 32'(pv_f), 0);
    end
    chk("load_pv_end", 32'(pv_f), 1);
    chk("load_period_end", 32'(per_f), 255);
    chk("load_gal_period", 32'(per_g), 255);

    // Random stalls must not change the measured period.
    cycle(1'b0, 1'b1, 1'b0, 8'h5A);
    n = 0; iter = 0;
    while (n < 255 && iter < 5000) begin
      e = 1'($urandom_range(0, 1));
      cycle(1'b0, 1'b0, e, 8'h5A);
      if (e) n++;
      iter++;
    end
    chk("rand_pv", 32'(pv_f), 1);
    chk("rand_period", 32'(per_f), 255);
    chk("rand_gal_period", 32'(per_g), 255);

    // Zero seed is replaced by 1 and flagged.
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("zero_q", 32'(q_f), 32'h01);
    chk("zero_flag", 32'(zs_f), 1);
    for (int i = 0; i < 255; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
    chk("zero_pv", 32'(pv_f), 1);
    chk("zero_period", 32'(per_f), 255);
    chk("zero_flag_sticky", 32'(zs_f), 1);

    // Mid-run reset clears everything and restarts counting.
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0, 1'b1, 8'h77);
    cycle(1'b1, 1'b0, 1'b1, 8'h77);
    chk("mrst_q", 32'(q_f), 32'h77);
    chk("mrst_pv", 32'(pv_f), 0);
    chk("mrst_nr", 32'(nr_f), 0);
    chk("mrst_zs", 32'(zs_f), 0);
    chk("mrst_period", 32'(per_f), 0);
    for (int i = 1; i <= 255; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h77);
      if (i == 254) chk("mrst_pv_at254", 32'(pv_f), 0);
    end
    chk("mrst_pv_end", 32'(pv_f), 1);
    chk("mrst_period_end", 32'(per_f), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
